// File: rtl/spu_issue_scoreboard_if.sv
// spu_issue_scoreboard_if -- candidate/issue bundle between the SPU
// decode stage (master) and the dual-issue scoreboard (slave).
// Carries both slots' candidate fields, the global freeze, the issue
// grants, stall status, the stall counter and the per-register pend flags.
interface spu_issue_scoreboard_if #(
  parameter int NREG = 128,
  parameter int AW   = 7,
  parameter int LW   = 4,
  parameter int SCW  = 16
);

  // Global hold from the pipeline owner
  logic            freeze;

  // Slot 0 (even pipe) candidate
  logic            vld_0;
  logic [AW-1:0]   ra_0;
  logic [AW-1:0]   rb_0;
  logic [AW-1:0]   rc_0;
  logic [2:0]      use_0;
  logic [AW-1:0]   rt_0;
  logic [LW-1:0]   lat_0;

  // Slot 1 (odd pipe) candidate
  logic            vld_1;
  logic [AW-1:0]   ra_1;
  logic [AW-1:0]   rb_1;
  logic [AW-1:0]   rc_1;
  logic [2:0]      use_1;
  logic [AW-1:0]   rt_1;
  logic [LW-1:0]   lat_1;

  // Scoreboard results
  logic            issue_0;
  logic            issue_1;
  logic            stall;
  logic [SCW-1:0]  stall_cnt;
  logic [NREG-1:0] pend;

  // Decode side: presents candidates, observes grants
  modport master (
    output freeze,
    output vld_0, ra_0, rb_0, rc_0, use_0, rt_0, lat_0,
    output vld_1, ra_1, rb_1, rc_1, use_1, rt_1, lat_1,
    input  issue_0, issue_1, stall, stall_cnt, pend
  );

  // Scoreboard side: consumes candidates, produces grants
  modport slave (
    input  freeze,
    input  vld_0, ra_0, rb_0, rc_0, use_0, rt_0, lat_0,
    input  vld_1, ra_1, rb_1, rc_1, use_1, rt_1, lat_1,
    output issue_0, issue_1, stall, stall_cnt, pend
  );

endinterface

// File: rtl/spu_issue_scoreboard.sv
// spu_issue_scoreboard -- dual-issue register scoreboard for the SPU.
// Tracks a per-register writeback countdown and grants in-order issue
// to the even (slot 0) and odd (slot 1) pipes, blocking RAW, WAW and
// intra-pair hazards. Counts stall cycles with saturation.
// Optional feature macro: SPU_SCOREBOARD_FWD_EN -- when defined a source
// is ready one cycle early (cnt <= 1) using register-file write-through.
module spu_issue_scoreboard #(
  parameter int NREG = 128,
  parameter int AW   = 7,
  parameter int LW   = 4,
  parameter int SCW  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  spu_issue_scoreboard_if.slave sb
);

  // Countdown state: cnt_q[r] = cycles until the in-flight write to r lands
  logic [LW-1:0]  cnt_q [NREG];
  logic [LW-1:0]  cnt_d [NREG];
  logic [SCW-1:0] stall_cnt_q;
  logic [SCW-1:0] stall_cnt_d;

  // Per-slot hazard terms
  logic src_ok_0, src_ok_1;
  logic waw_ok_0, waw_ok_1;
  logic pair_haz;
  logic issue_0, issue_1, stall;

  // A source is readable once its pending write has landed (or is landing
  // this cycle, when the register file forwards write data to the read).
  function automatic logic src_ready(input logic [LW-1:0] c);
`ifdef SPU_SCOREBOARD_FWD_EN
    return (c <= LW'(1));
`else
    return (c == '0);
`endif
  endfunction

  // Every used source of a slot must be ready; bits of use are {ra, rb, rc}
  function automatic logic srcs_ready(input logic [2:0]    use_m,
                                      input logic [LW-1:0] c_a,
                                      input logic [LW-1:0] c_b,
                                      input logic [LW-1:0] c_c);
    return (!use_m[2] || src_ready(c_a)) &&
           (!use_m[1] || src_ready(c_b)) &&
           (!use_m[0] || src_ready(c_c));
  endfunction

  // A later write must not land before an earlier write to the same register
  function automatic logic waw_ok(input logic [LW-1:0] lat,
                                  input logic [LW-1:0] c_t);
    return (lat == '0) || (c_t < lat);
  endfunction

  // Hazard evaluation and issue decision for both slots
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path can leave it unassigned and infer a latch.
    src_ok_0 = srcs_ready(sb.use_0, cnt_q[sb.ra_0], cnt_q[sb.rb_0], cnt_q[sb.rc_0]);
    src_ok_1 = srcs_ready(sb.use_1, cnt_q[sb.ra_1], cnt_q[sb.rb_1], cnt_q[sb.rc_1]);
    waw_ok_0 = waw_ok(sb.lat_0, cnt_q[sb.rt_0]);
    waw_ok_1 = waw_ok(sb.lat_1, cnt_q[sb.rt_1]);

    // Slot 1 may not read or overwrite what slot 0 is about to write
    pair_haz = 1'b0;
    if (sb.vld_0 && (sb.lat_0 != '0)) begin
      pair_haz = (sb.use_1[2] && (sb.ra_1 == sb.rt_0)) ||
                 (sb.use_1[1] && (sb.rb_1 == sb.rt_0)) ||
                 (sb.use_1[0] && (sb.rc_1 == sb.rt_0)) ||
                 ((sb.lat_1 != '0) && (sb.rt_1 == sb.rt_0));
    end

    issue_0 = sb.vld_0 && !sb.freeze && !reset && src_ok_0 && waw_ok_0;

    // Program order: slot 1 only goes with or without (never ahead of) slot 0
    issue_1 = sb.vld_1 && !sb.freeze && !reset && (issue_0 || !sb.vld_0) &&
              src_ok_1 && waw_ok_1 && !pair_haz;

    stall   = !sb.freeze && !reset &&
              ((sb.vld_0 && !issue_0) || (sb.vld_1 && !issue_1));
  end

  // Countdown next state: load on issue, otherwise count down; hold on freeze
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!sb.freeze) begin
        if (issue_0 && (sb.lat_0 != '0) && (sb.rt_0 == AW'(r))) begin
          cnt_d[r] = sb.lat_0;
        end else if (issue_1 && (sb.lat_1 != '0) && (sb.rt_1 == AW'(r))) begin
          cnt_d[r] = sb.lat_1;
        end else if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - LW'(1);
        end
      end
    end
  end

  // Stall counter next state, saturating at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + SCW'(1);
    end
  end

  // Countdown array register
  // NOTE: the countdown array is flop-based state, not a RAM, and it must
  // read idle straight out of reset, so every entry is cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge value regardless of statement order.
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Output drive: grants, stall, counter and pending flags
  always_comb begin
    sb.issue_0   = issue_0;
    sb.issue_1   = issue_1;
    sb.stall     = stall;
    sb.stall_cnt = stall_cnt_q;
    for (int r = 0; r < NREG; r++) begin
      sb.pend[r] = (cnt_q[r] != '0);
    end
  end

endmodule
